timer_alarm_ctrl: RTL
=====================

// Module: timer_alarm_ctrl
// PURPOSE
//  Downstream of the remaining-time subtractor in the RTC timer path. Takes
//  remaining time hh:mm:ss in packed BCD, sampled on every RTC read strobe, and
//  detects timer expiry at 00:00:00. A missed zero (RTC wrap) also counts as
//  expiry. On expiry it drives a blinking alarm output for at most RING_SECS
//  seconds, or until the user acknowledges it. It also flags invalid BCD samples.
// PARAMETERS
//  RING_SECS  30  max alarm duration in 1 Hz ticks (1..255)
//  CNT_W      8   width of the ring-second counter, >= clog2(RING_SECS+1)
// PORTS
//  clk            in   1  system clock, single clock domain
//  reset          in   1  asynchronous, active-high reset
//  tick_1hz       in   1  1-cycle pulse once per second, synchronous to clk
//  timer_en       in   1  level: timer function enabled by user/config
//  muestra_valida in   1  1-cycle strobe: hora/minuto/segundo_in hold a fresh sample
//  hora_in        in   8  remaining hours, BCD, 00..23
//  minuto_in      in   8  remaining minutes, BCD, 00..59
//  segundo_in     in   8  remaining seconds, BCD, 00..59
//  ack            in   1  1-cycle pulse, debounced user acknowledge
//  alarma         out  1  level: high while in RINGING
//  parpadeo       out  1  blink drive: toggles each tick_1hz in RINGING, else 0
//  timer_fin      out  1  1-cycle pulse on the ARMED->RINGING transition
//  error_bcd      out  1  sticky: an invalid sample was seen; cleared by reset or IDLE
//  estado         out  2  current state encoding, for debug/display
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, prev sample 24'h235959, counter 0.
//  Sample validity: each nibble <= 9; hh <= 8'h23, mm/ss <= 8'h59.
//   - Invalid sample: ignored for state/compare; error_bcd set the next cycle.
//  Compare: {hh,mm,ss} is compared as a 24-bit unsigned number; valid BCD keeps
//   the ordering. prev is updated on each valid sample while ARMED.
//  States: IDLE=2'd0, ARMED=2'd1, RINGING=2'd2, DONE=2'd3.
//   IDLE   : timer_en=1 -> ARMED; prev <= 24'h235959; error_bcd cleared.
//   ARMED  : on a valid sample S, go to RINGING if S==0, or if S>prev (wrap
//            detected). Otherwise prev <= S. ack is ignored in this state.
//   RINGING: counter starts at 0 on entry. Each tick_1hz toggles parpadeo and
//            increments the counter. Exit to DONE on ack, or on the tick that
//            brings the counter to RING_SECS. If ack and tick arrive in the same
//            cycle, ack wins; no toggle.
//   DONE   : alarma=0, parpadeo=0; stays here until timer_en=0 -> IDLE.
//  timer_en=0 in any state -> IDLE on the next edge. This overrides all other events.
//  Latency: alarma and timer_fin go high 1 cycle after the strobe carrying the
//   expiring sample. Samples are ignored while RINGING and DONE.
//  parpadeo starts at 1 on entry to RINGING. Both alarma and parpadeo are
//   registered outputs (glitch-free).
//  Reset asserted mid-ring: outputs drop asynchronously to 0 and state is IDLE.
// STRUCTURE
//  Shared package timer_pkg: state encoding constants, T_MAX_H=8'h23,
//   T_MAX_MS=8'h59, T_ZERO=24'h000000, T_FULL=24'h235959.
//  One sub-module, timer_bcd_check: combinational; inputs hh/mm/ss, output
//   valid. Also reusable at the input of the subtractor stage.
//  Rest of the logic is inline: a state register, a prev register, the ring
//   counter and the output registers.
// TESTING
//  1. timer_en=1; samples 00:00:02, 00:00:01, 00:00:00 -> timer_fin pulse and
//     alarma=1 one cycle after the 3rd strobe; estado=2.
//  2. ARMED, prev 00:00:01; next sample 23:59:58 -> wrap expiry, alarma=1.
//  3. RINGING with RING_SECS=3; send 3 ticks and no ack -> parpadeo 1,0,1,0;
//     after the 3rd tick estado=3, alarma=0.
//  4. RINGING; ack and tick_1hz in the same cycle -> DONE, parpadeo=0, no toggle.
//  5. ARMED; sample 8'h1A:00:00 -> error_bcd=1, state stays ARMED; then
//     00:00:00 -> ringing.
//  6. RINGING; assert reset mid-cycle -> alarma/parpadeo 0 before the next
//     edge; drop timer_en in DONE -> IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the RTC timer path: FSM state encoding, BCD limits
// and the time constants used by the alarm controller and the BCD checker.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [7:0]  T_MAX_H  = 8'h23;
  localparam logic [7:0]  T_MAX_MS = 8'h59;
  localparam logic [23:0] T_ZERO   = 24'h000000;
  localparam logic [23:0] T_FULL   = 24'h235959;

  function automatic logic bcd_digit_ok(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/timer_bcd_check.sv
// Combinational validity check of a packed BCD hh:mm:ss value; also meant to
// sit in front of the remaining-time subtractor.
module timer_bcd_check
  import timer_pkg::*;
(
  input  logic [7:0] hh_i,
  input  logic [7:0] mm_i,
  input  logic [7:0] ss_i,
  output logic       valid_o
);

  logic digits_ok;

  // With every nibble a legal digit, plain magnitude compares bound each field.
  always_comb begin
    digits_ok = bcd_digit_ok(hh_i[7:4]) && bcd_digit_ok(hh_i[3:0]) &&
                bcd_digit_ok(mm_i[7:4]) && bcd_digit_ok(mm_i[3:0]) &&
                bcd_digit_ok(ss_i[7:4]) && bcd_digit_ok(ss_i[3:0]);
    valid_o   = digits_ok && (hh_i <= T_MAX_H) && (mm_i <= T_MAX_MS) &&
                (ss_i <= T_MAX_MS);
  end

endmodule

// File: rtl/timer_alarm_ctrl.sv
// Timer expiry detector and alarm sequencer: watches BCD remaining-time samples,
// rings a blinking alarm on expiry (or a missed zero) until ack or timeout.
module timer_alarm_ctrl
  import timer_pkg::*;
#(
  parameter int RING_SECS = 30,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       timer_en,
  input  logic       muestra_valida,
  input  logic [7:0] hora_in,
  input  logic [7:0] minuto_in,
  input  logic [7:0] segundo_in,
  input  logic       ack,
  output logic       alarma,
  output logic       parpadeo,
  output logic       timer_fin,
  output logic       error_bcd,
  output logic [1:0] estado
);

  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);

  state_e             state_q, state_d;
  logic [23:0]        prev_q, prev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               alarma_q, alarma_d;
  logic               parpadeo_q, parpadeo_d;
  logic               fin_q, fin_d;
  logic               err_q, err_d;

  logic [23:0]        sample;
  logic               sample_ok;
  logic               good_sample;
  logic               bad_sample;
  logic               expire;
  logic               last_tick;

  assign sample = {hora_in, minuto_in, segundo_in};

  timer_bcd_check u_bcd_check (
    .hh_i   (hora_in),
    .mm_i   (minuto_in),
    .ss_i   (segundo_in),
    .valid_o(sample_ok)
  );

  // A sample larger than the previous one means the countdown wrapped past zero.
  assign good_sample = muestra_valida && sample_ok;
  assign bad_sample  = muestra_valida && !sample_ok;
  assign expire      = good_sample && ((sample == T_ZERO) || (sample > prev_q));
  assign last_tick   = tick_1hz && (cnt_q == RING_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!timer_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ARMED;
        ST_ARMED:   if (expire) state_d = ST_RINGING;
        ST_RINGING: if (ack || last_tick) state_d = ST_DONE;
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are computed from the upcoming state so they can be registered.
  always_comb begin
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    alarma_d   = (state_d == ST_RINGING);
    fin_d      = (state_q == ST_ARMED) && (state_d == ST_RINGING);
    parpadeo_d = 1'b0;
    err_d      = err_q || bad_sample;

    if (state_q == ST_IDLE) begin
      prev_d = T_FULL;
      err_d  = 1'b0;
    end

    if ((state_q == ST_ARMED) && good_sample && !expire) begin
      prev_d = sample;
    end

    if (state_d == ST_RINGING) begin
      if (state_q != ST_RINGING) begin
        cnt_d      = '0;
        parpadeo_d = 1'b1;
      end else if (tick_1hz) begin
        cnt_d      = cnt_q + CNT_W'(1);
        parpadeo_d = !parpadeo_q;
      end else begin
        parpadeo_d = parpadeo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= T_FULL;
      cnt_q      <= '0;
      alarma_q   <= 1'b0;
      parpadeo_q <= 1'b0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      alarma_q   <= alarma_d;
      parpadeo_q <= parpadeo_d;
      fin_q      <= fin_d;
      err_q      <= err_d;
    end
  end

  assign alarma    = alarma_q;
  assign parpadeo  = parpadeo_q;
  assign timer_fin = fin_q;
  assign error_bcd = err_q;
  assign estado    = state_q;

endmodule
